aes_ctr_engine: RTL

AES_CTR_ENGINE -- requirements
Module: aes_ctr_engine

---
 rtl/aes_ctr_engine.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/aes_ctr_engine.sv
// aes_ctr_engine: ECB/CTR sequencing wrapper around an external block-cipher core.
//
// Ports:
//   clk, rst                       clock, asynchronous active-high reset
//   cfg_we/cfg_mode/cfg_key/cfg_iv configuration load (mode 0 = ECB, 1 = CTR)
//   cfg_err                        one-cycle pulse when a config load is rejected
//   in_valid/in_ready/in_data      plaintext input stream (valid-ready)
//   out_valid/out_ready/out_data   result output stream (valid-ready)
//   core_start/core_key/core_data  request to the cipher core
//   core_cipher/core_valid         core result and its done pulse
//   blk_cnt                        count of blocks pushed to the output FIFO
//
// One block is in flight at a time. A block is only accepted when the output
// FIFO has a free slot, so the core result can always be pushed on arrival.
module aes_ctr_engine #(
  parameter int DATA_WIDTH = 128,
  parameter int KEY_WIDTH  = 128,
  parameter int CTR_WIDTH  = 32,
  parameter int OUT_DEPTH  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cfg_we,
  input  logic                  cfg_mode,
  input  logic [KEY_WIDTH-1:0]  cfg_key,
  input  logic [DATA_WIDTH-1:0] cfg_iv,
  output logic                  cfg_err,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  core_start,
  output logic [KEY_WIDTH-1:0]  core_key,
  output logic [DATA_WIDTH-1:0] core_data,
  input  logic [DATA_WIDTH-1:0] core_cipher,
  input  logic                  core_valid,
  output logic [31:0]           blk_cnt
);

  localparam int PW = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
  localparam int CW = $clog2(OUT_DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C   = CW'(OUT_DEPTH);
  localparam logic [PW-1:0] LAST_PTR  = PW'(OUT_DEPTH - 1);
  // Selects the low CTR_WIDTH bits that take part in the counter increment.
  localparam logic [DATA_WIDTH-1:0] CTR_MASK = {DATA_WIDTH{1'b1}} >> (DATA_WIDTH - CTR_WIDTH);

  typedef enum logic [1:0] {IDLE, START, WAIT} state_t;

  state_t                state;
  logic [KEY_WIDTH-1:0]  key;
  logic                  mode;
  logic                  key_loaded;
  logic [DATA_WIDTH-1:0] ctr_reg;
  logic [DATA_WIDTH-1:0] held;

  logic [DATA_WIDTH-1:0] mem [OUT_DEPTH];
  logic [PW-1:0]         wr_ptr, rd_ptr;
  logic [CW-1:0]         count;

  logic                  xfer, push, pop;
  logic [DATA_WIDTH-1:0] result, ctr_next;

  assign in_ready  = (state == IDLE) && key_loaded && (count < DEPTH_C);
  assign xfer      = in_valid && in_ready;
  // A done pulse only counts while a block is actually outstanding.
  assign push      = (state == WAIT) && core_valid;
  assign out_valid = (count != '0);
  assign pop       = out_valid && out_ready;
  assign out_data  = mem[rd_ptr];

  assign core_key  = key;
  assign core_data = mode ? ctr_reg : held;
  assign result    = mode ? (core_cipher ^ held) : core_cipher;
  assign ctr_next  = (ctr_reg & ~CTR_MASK) | ((ctr_reg + DATA_WIDTH'(1)) & CTR_MASK);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      key        <= '0;
      mode       <= 1'b0;
      key_loaded <= 1'b0;
      ctr_reg    <= '0;
      held       <= '0;
      core_start <= 1'b0;
      cfg_err    <= 1'b0;
      blk_cnt    <= '0;
    end else begin
      core_start <= 1'b0;
      cfg_err    <= 1'b0;
      if (cfg_we) begin
        if (state == IDLE) begin
          key        <= cfg_key;
          mode       <= cfg_mode;
          ctr_reg    <= cfg_iv;
          key_loaded <= 1'b1;
        end else begin
          cfg_err <= 1'b1;
        end
      end
      case (state)
        IDLE: if (xfer) begin
          held       <= in_data;
          core_start <= 1'b1;
          state      <= START;
        end
        START: state <= WAIT;
        WAIT: if (core_valid) begin
          state   <= IDLE;
          blk_cnt <= blk_cnt + 32'd1;
          if (mode) ctr_reg <= ctr_next;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // FIFO bookkeeping; storage itself needs no reset since count gates visibility.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + PW'(1);
      if (pop)  rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= result;
  end

endmodule
